// File: rtl/hpdcache_mem_resp_pkg.sv
`default_nettype none
// hpdcache_mem_resp_pkg -- shared types for the memory-side responder of the cache refill/write-back port.
// Revision: 1.0
package hpdcache_mem_resp_pkg;

  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefDataWidth  = 64;
  localparam int unsigned DefIdWidth    = 4;
  localparam int unsigned DefLenWidth   = 3;
  localparam int unsigned DefDepthWords = 1024;
  localparam int unsigned BeatBytes     = DefDataWidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_DATA  = 2'd2,
    ST_WR_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefLenWidth-1:0]  len;
    logic [DefIdWidth-1:0]   id;
  } rd_req_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [DefIdWidth-1:0]   id;
    logic                    last;
    logic                    error;
  } rd_resp_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefIdWidth-1:0]   id;
  } wr_req_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic                  error;
  } wr_resp_t;

endpackage
`default_nettype wire

// File: rtl/hpdcache_mem_responder_bram.sv
`default_nettype none
// mem_resp_bram -- single-port synchronous word RAM, per-byte write enable, 1-cycle read latency.
// Revision: 1.0
module mem_resp_bram #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 1024,
  parameter int unsigned AddrBits  = $clog2(Depth)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [DataWidth/8-1:0] we,
  input  logic [AddrBits-1:0]    addr,
  input  logic [DataWidth-1:0]   wdata,
  output logic [DataWidth-1:0]   rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_mem_responder.sv
`default_nettype none
// hpdcache_mem_responder -- target end of the cache memory read-burst / byte-masked write channels.
// Revision: 1.0
module hpdcache_mem_responder
  import hpdcache_mem_resp_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned IdWidth    = DefIdWidth,
  parameter int unsigned LenWidth   = DefLenWidth,
  parameter int unsigned DepthWords = DefDepthWords
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_read_valid_i,
  output logic                   req_read_ready_o,
  input  logic [AddrWidth-1:0]   req_read_addr_i,
  input  logic [LenWidth-1:0]    req_read_len_i,
  input  logic [IdWidth-1:0]     req_read_id_i,
  output logic                   resp_read_valid_o,
  input  logic                   resp_read_ready_i,
  output logic [DataWidth-1:0]   resp_read_data_o,
  output logic [IdWidth-1:0]     resp_read_id_o,
  output logic                   resp_read_last_o,
  output logic                   resp_read_error_o,
  input  logic                   req_write_valid_i,
  output logic                   req_write_ready_o,
  input  logic [AddrWidth-1:0]   req_write_addr_i,
  input  logic [IdWidth-1:0]     req_write_id_i,
  input  logic                   req_write_data_valid_i,
  output logic                   req_write_data_ready_o,
  input  logic [DataWidth-1:0]   req_write_data_i,
  input  logic [DataWidth/8-1:0] req_write_be_i,
  output logic                   resp_write_valid_o,
  input  logic                   resp_write_ready_i,
  output logic [IdWidth-1:0]     resp_write_id_o,
  output logic                   resp_write_error_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffBits  = $clog2(NumBytes);
  localparam int unsigned RamAw    = $clog2(DepthWords);
  localparam logic [AddrWidth-1:0] DepthLim = AddrWidth'(DepthWords);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
  localparam logic [LenWidth:0]    LenOne   = (LenWidth + 1)'(1);

  state_t state, state_next;

  logic [AddrWidth-1:0] rd_idx;
  logic [LenWidth:0]    rd_left;
  logic [IdWidth-1:0]   rd_id;
  logic                 s1_vld, s1_err, s1_last;
  rd_resp_t             fifo [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic [AddrWidth-1:0] wr_addr;
  wr_resp_t             wr_resp;

  logic                 rd_accept, wr_accept, issue, pop, data_hs, wr_oob;
  logic [AddrWidth-1:0] wr_word;
  logic [2:0]           occ;
  logic                 ram_en;
  logic [NumBytes-1:0]  ram_we;
  logic [RamAw-1:0]     ram_addr;
  logic [DataWidth-1:0] ram_rdata;
  rd_resp_t             head;

  assign head      = fifo[rd_ptr];
  assign rd_accept = (state == ST_IDLE) && req_read_valid_i;
  assign wr_accept = (state == ST_IDLE) && !req_read_valid_i && req_write_valid_i;
  assign pop       = (count != 2'd0) && resp_read_ready_i;
  assign data_hs   = (state == ST_WR_DATA) && req_write_data_valid_i;
  assign wr_word   = wr_addr >> OffBits;
  assign wr_oob    = wr_word >= DepthLim;

  // Beats buffered plus the one in the RAM stage must leave room for a new issue
  assign occ   = {1'b0, count} + 3'(s1_vld) - 3'(pop);
  assign issue = (state == ST_RD_BURST) && (rd_left != '0) && (occ <= 3'd1);

  assign ram_en   = issue || data_hs;
  assign ram_we   = (data_hs && !wr_oob) ? req_write_be_i : '0;
  assign ram_addr = (state == ST_WR_DATA) ? wr_word[RamAw-1:0] : rd_idx[RamAw-1:0];

  mem_resp_bram #(
    .DataWidth (DataWidth),
    .Depth     (DepthWords)
  ) u_bram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_write_data_i),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rd_accept)      state_next = ST_RD_BURST;
        else if (wr_accept) state_next = ST_WR_DATA;
      end
      ST_RD_BURST: if (pop && head.last)          state_next = ST_IDLE;
      ST_WR_DATA:  if (req_write_data_valid_i)    state_next = ST_WR_RESP;
      ST_WR_RESP:  if (resp_write_ready_i)        state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_read_ready_o       = 1'b0;
    req_write_ready_o      = 1'b0;
    req_write_data_ready_o = 1'b0;
    resp_write_valid_o     = 1'b0;
    if (!reset_i) begin
      case (state)
        ST_IDLE: begin
          req_read_ready_o  = 1'b1;
          req_write_ready_o = !req_read_valid_i;
        end
        ST_WR_DATA: req_write_data_ready_o = 1'b1;
        ST_WR_RESP: resp_write_valid_o     = 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_read_valid_o  = (count != 2'd0);
  assign resp_read_data_o   = resp_read_valid_o ? head.data  : '0;
  assign resp_read_id_o     = resp_read_valid_o ? head.id    : '0;
  assign resp_read_last_o   = resp_read_valid_o && head.last;
  assign resp_read_error_o  = resp_read_valid_o && head.error;
  assign resp_write_id_o    = wr_resp.id;
  assign resp_write_error_o = wr_resp.error;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_idx  <= '0;
      rd_left <= '0;
      rd_id   <= '0;
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_last <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      wr_addr <= '0;
      wr_resp <= '0;
    end else begin
      if (rd_accept) begin
        rd_idx  <= req_read_addr_i >> OffBits;
        rd_left <= {1'b0, req_read_len_i} + LenOne;
        rd_id   <= req_read_id_i;
      end else if (issue) begin
        rd_idx  <= rd_idx + AddrOne;
        rd_left <= rd_left - LenOne;
      end
      s1_vld <= issue;
      if (issue) begin
        s1_err  <= rd_idx >= DepthLim;
        s1_last <= rd_left == LenOne;
      end
      // Out-of-range beats return zero data regardless of what the aliased RAM row holds
      if (s1_vld) begin
        fifo[wr_ptr] <= '{data: (s1_err ? '0 : ram_rdata), id: rd_id, last: s1_last, error: s1_err};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(s1_vld) - 2'(pop);
      if (wr_accept) begin
        wr_addr    <= req_write_addr_i;
        wr_resp.id <= req_write_id_i;
      end
      if (data_hs) wr_resp.error <= wr_oob;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mem_responder.sv
`default_nettype none
// tb_hpdcache_mem_responder -- directed + randomized bench against a word-array memory model.
// Revision: 1.0
module tb_hpdcache_mem_responder;

  localparam int AW = 32, DW = 64, IW = 4, LW = 3, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_read_valid_i = 1'b0;
  logic          req_read_ready_o;
  logic [AW-1:0] req_read_addr_i = '0;
  logic [LW-1:0] req_read_len_i = '0;
  logic [IW-1:0] req_read_id_i = '0;
  logic          resp_read_valid_o;
  logic          resp_read_ready_i = 1'b0;
  logic [DW-1:0] resp_read_data_o;
  logic [IW-1:0] resp_read_id_o;
  logic          resp_read_last_o;
  logic          resp_read_error_o;
  logic          req_write_valid_i = 1'b0;
  logic          req_write_ready_o;
  logic [AW-1:0] req_write_addr_i = '0;
  logic [IW-1:0] req_write_id_i = '0;
  logic          req_write_data_valid_i = 1'b0;
  logic          req_write_data_ready_o;
  logic [DW-1:0] req_write_data_i = '0;
  logic [7:0]    req_write_be_i = '0;
  logic          resp_write_valid_o;
  logic          resp_write_ready_i = 1'b0;
  logic [IW-1:0] resp_write_id_o;
  logic          resp_write_error_o;

  hpdcache_mem_responder #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .LenWidth(LW), .DepthWords(DEPTH)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_read_valid_i(req_read_valid_i), .req_read_ready_o(req_read_ready_o),
    .req_read_addr_i(req_read_addr_i), .req_read_len_i(req_read_len_i), .req_read_id_i(req_read_id_i),
    .resp_read_valid_o(resp_read_valid_o), .resp_read_ready_i(resp_read_ready_i),
    .resp_read_data_o(resp_read_data_o), .resp_read_id_o(resp_read_id_o),
    .resp_read_last_o(resp_read_last_o), .resp_read_error_o(resp_read_error_o),
    .req_write_valid_i(req_write_valid_i), .req_write_ready_o(req_write_ready_o),
    .req_write_addr_i(req_write_addr_i), .req_write_id_i(req_write_id_i),
    .req_write_data_valid_i(req_write_data_valid_i), .req_write_data_ready_o(req_write_data_ready_o),
    .req_write_data_i(req_write_data_i), .req_write_be_i(req_write_be_i),
    .resp_write_valid_o(resp_write_valid_o), .resp_write_ready_i(resp_write_ready_i),
    .resp_write_id_o(resp_write_id_o), .resp_write_error_o(resp_write_error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input logic [63:0] data, input logic [7:0] be);
    int n;
    logic [31:0] word;
    logic oob;
    word = addr >> 3;
    oob  = (word >= 32'(DEPTH));
    req_write_addr_i = addr;
    req_write_id_i = id;
    req_write_valid_i = 1'b1;
    #1;
    n = 0;
    while (req_write_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    check("wr_accept_timeout", 128'(n < 100), 128'(1));
    @(posedge clk); #1;
    req_write_valid_i = 1'b0;
    check("wr_resp_early", 128'(resp_write_valid_o), 128'(0));
    req_write_data_i = data;
    req_write_be_i = be;
    req_write_data_valid_i = 1'b1;
    #1;
    check("wr_data_ready", 128'(req_write_data_ready_o), 128'(1));
    @(posedge clk); #1;
    req_write_data_valid_i = 1'b0;
    if (!oob) begin
      for (int b = 0; b < 8; b++) if (be[b]) mdl[word[9:0]][b*8 +: 8] = data[b*8 +: 8];
    end
    repeat ($urandom_range(0, 2)) begin
      check("wr_resp_hold", 128'({resp_write_valid_o, resp_write_id_o, resp_write_error_o}),
            128'({1'b1, id, oob}));
      tick();
    end
    check("wr_resp", 128'({resp_write_valid_o, resp_write_id_o, resp_write_error_o}),
          128'({1'b1, id, oob}));
    resp_write_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_write_ready_i = 1'b0;
    check("wr_resp_drop", 128'(resp_write_valid_o), 128'(0));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ready
  task automatic do_read(input logic [31:0] addr, input logic [2:0] len, input logic [3:0] id,
                         input int mode, output logic [63:0] first_data);
    int n, cyc, beat, first_cyc;
    logic rdy, held, exp_err;
    logic [31:0] word;
    logic [63:0] exp_data;
    logic [69:0] hold_vec;
    first_data = '0;
    hold_vec = '0;
    req_read_addr_i = addr;
    req_read_len_i = len;
    req_read_id_i = id;
    req_read_valid_i = 1'b1;
    #1;
    n = 0;
    while (req_read_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    check("rd_accept_timeout", 128'(n < 100), 128'(1));
    @(posedge clk); #1;
    req_read_valid_i = 1'b0;
    beat = 0; cyc = 0; first_cyc = -1; held = 1'b0;
    while (beat <= int'(len) && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      resp_read_ready_i = rdy;
      #1;
      if (held)
        check("rd_stall_hold", 128'({resp_read_valid_o, resp_read_data_o, resp_read_id_o,
                                     resp_read_last_o, resp_read_error_o}), 128'({1'b1, hold_vec}));
      if (resp_read_valid_o === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        word = (addr >> 3) + 32'(beat);
        exp_err = (word >= 32'(DEPTH));
        exp_data = exp_err ? 64'h0 : mdl[word[9:0]];
        if (rdy) begin
          check("rd_data", 128'(resp_read_data_o), 128'(exp_data));
          check("rd_id_last_err", 128'({resp_read_id_o, resp_read_last_o, resp_read_error_o}),
                128'({id, beat == int'(len), exp_err}));
          if (beat == 0) first_data = resp_read_data_o;
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_vec = {resp_read_data_o, resp_read_id_o, resp_read_last_o, resp_read_error_o};
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_beat_count", 128'(beat), 128'(int'(len) + 1));
    check("rd_first_latency", 128'(first_cyc), 128'(2));
    resp_read_ready_i = 1'b0;
    #1;
    check("rd_no_extra_beat", 128'(resp_read_valid_o), 128'(0));
    check("rd_back_idle", 128'(req_read_ready_o), 128'(1));
  endtask

  initial begin
    logic [63:0] fd;
    logic [31:0] w;
    int n, hs;

    // Reset state
    tick(); tick();
    check("rst_readies", 128'({req_read_ready_o, req_write_ready_o, req_write_data_ready_o}), 128'(0));
    check("rst_valids", 128'({resp_read_valid_o, resp_write_valid_o}), 128'(0));
    check("rst_resp_fields", 128'({resp_read_data_o, resp_read_id_o, resp_read_last_o,
                                   resp_read_error_o, resp_write_id_o, resp_write_error_o}), 128'(0));
    reset_i = 1'b0;
    #1;
    check("idle_readies", 128'({req_read_ready_o, req_write_ready_o}), 128'(3));

    // Preload every word the later reads touch
    for (int i = 0; i < 16; i++) do_write(32'(i * 8), 4'(i), {$urandom, $urandom}, 8'hFF);
    for (int i = 1020; i < 1024; i++) do_write(32'(i * 8), 4'(i), {$urandom, $urandom}, 8'hFF);

    // Full write then single-beat readback
    do_write(32'h40, 4'd3, 64'h1122334455667788, 8'hFF);
    do_read(32'h40, 3'd0, 4'd5, 0, fd);
    check("full_write_readback", 128'(fd), 128'(64'h1122334455667788));

    // Byte-masked merge
    do_write(32'h40, 4'd7, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_read(32'h40, 3'd0, 4'd1, 0, fd);
    check("be_merge", 128'(fd), 128'(64'h11223344AAAAAAAA));

    // 8-beat burst under 1,0,0,1 backpressure
    do_read(32'h0, 3'd7, 4'd2, 1, fd);

    // Burst running off the end of the RAM
    do_read(32'((DEPTH - 2) * 8), 3'd3, 4'd11, 0, fd);

    // Out-of-range write must not alias into word 0
    do_write(32'(DEPTH * 8), 4'd9, 64'hDEADBEEFCAFEF00D, 8'hFF);
    do_read(32'h0, 3'd0, 4'd9, 0, fd);

    // Simultaneous read and write: read wins, write follows on first IDLE cycle
    req_write_addr_i = 32'h48;
    req_write_id_i = 4'd6;
    req_write_valid_i = 1'b1;
    req_read_addr_i = 32'h40;
    req_read_len_i = 3'd1;
    req_read_id_i = 4'd2;
    req_read_valid_i = 1'b1;
    #1;
    check("simul_priority", 128'({req_read_ready_o, req_write_ready_o}), 128'(2));
    do_read(32'h40, 3'd1, 4'd2, 0, fd);
    check("simul_wr_ready_after", 128'(req_write_ready_o), 128'(1));
    do_write(32'h48, 4'd6, 64'h0123456789ABCDEF, 8'hF0);
    do_read(32'h48, 3'd0, 4'd4, 2, fd);

    // Randomized mix
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1020, 1027)) : 32'($urandom_range(0, 15));
        do_write((w << 3) + 32'($urandom_range(0, 7)), 4'($urandom), {$urandom, $urandom}, 8'($urandom));
      end else begin
        w = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1020, 1023)) : 32'($urandom_range(0, 8));
        do_read((w << 3) + 32'($urandom_range(0, 7)), 3'($urandom), 4'($urandom), 2, fd);
      end
    end

    // Reset during beat 3 of an 8-beat burst
    req_read_addr_i = 32'h0;
    req_read_len_i = 3'd7;
    req_read_id_i = 4'd12;
    req_read_valid_i = 1'b1;
    #1;
    @(posedge clk); #1;
    req_read_valid_i = 1'b0;
    resp_read_ready_i = 1'b1;
    hs = 0; n = 0;
    while (hs < 2 && n < 50) begin
      #1;
      if (resp_read_valid_o === 1'b1) hs++;
      @(posedge clk); #1;
      n++;
    end
    #1;
    check("rst_mid_pre_valid", 128'({hs == 2, resp_read_valid_o}), 128'(3));
    reset_i = 1'b1;
    #1;
    check("rst_mid_valids", 128'({resp_read_valid_o, resp_write_valid_o}), 128'(0));
    check("rst_mid_readies", 128'({req_read_ready_o, req_write_ready_o}), 128'(0));
    tick(); tick();
    reset_i = 1'b0;
    #1;
    check("rst_release_idle", 128'({req_read_ready_o, req_write_ready_o}), 128'(3));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_stale_beat", 128'(resp_read_valid_o), 128'(0));
    end
    resp_read_ready_i = 1'b0;

    // Still functional after reset
    do_read(32'h40, 3'd2, 4'd8, 2, fd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
